uart_rx_param: RTL and testbench

Parametrised UART receiver: next generation of the fixed 9600-baud, 8N1 receiver. It adds configurable baud divisor, data width, parity and stop bits, an input synchroniser, false-start rejection, error flags and a one-cycle valid strobe. It also performs an integrated ASCII-digit decode, so it drops into the top level in place of the current receiver plus ASCII-to-decimal pair and feeds the 7-segment decoder directly.

---
 rtl/uart_rx_param.sv | 154 +++++++++++++++
 tb/tb_uart_rx_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with line synchroniser, false-start rejection,
// error flags, a one-cycle valid strobe and ASCII-digit decode of the last byte.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int BAUD_DIV   = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy,
    output logic [3:0] digit,
    output logic       digit_ok
);
    localparam int HALF = BAUD_DIV / 2;
    localparam int CW   = $clog2(BAUD_DIV + 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rx_s_q, rx_d_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d;
    logic [7:0]           dout_q, dout_d;
    logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d;
    logic                 tick, fall, last_data, last_stop;

    assign tick      = (cnt_q == CW'(1));
    assign fall      = rx_d_q & ~rx_s_q;
    assign last_data = (bit_q == 4'(DATA_BITS - 1));
    assign last_stop = (bit_q == 4'(STOP_BITS - 1));

    // Synchroniser and edge-detect flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (rx_s_q && cnt_q == CW'(BAUD_DIV - 1)) state_d = IDLE;
            IDLE:    if (fall) state_d = START;
            START:   if (tick) state_d = rx_s_q ? IDLE : DATA;
            DATA:    if (tick && last_data) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick && last_stop) state_d = IDLE;
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        busy = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);
    end

    // In ARM the counter measures the idle run; in a frame it times bit centres.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        dout_d  = dout_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        valid_d = 1'b0;
        case (state_q)
            ARM:  cnt_d = rx_s_q ? cnt_q + CW'(1) : '0;
            IDLE: if (fall) begin
                cnt_d  = CW'(HALF);
                bit_d  = '0;
                ferr_d = 1'b0;
                perr_d = 1'b0;
            end
            default: begin
                cnt_d = tick ? CW'(BAUD_DIV) : cnt_q - CW'(1);
                if (tick) begin
                    case (state_q)
                        DATA: begin
                            sh_d  = {rx_s_q, sh_q[DATA_BITS-1:1]};
                            bit_d = last_data ? 4'd0 : bit_q + 4'd1;
                        end
                        PARITY: perr_d = ((^sh_q) ^ rx_s_q) != (PARITY_ODD != 0);
                        STOP: begin
                            bit_d = bit_q + 4'd1;
                            if (!rx_s_q) ferr_d = 1'b1;
                            if (last_stop) begin
                                dout_d                  = '0;
                                dout_d[DATA_BITS-1:0]   = sh_q;
                                fe_d                    = ferr_q | ~rx_s_q;
                                pe_d                    = perr_q;
                                valid_d                 = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign digit_ok   = (dout_q >= 8'h30) && (dout_q <= 8'h39);
    assign digit      = digit_ok ? dout_q[3:0] : 4'hF;
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: instance 0 is 8N1, instance 1 is 7 data bits, even parity, 2 stops.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int BD   = 16;
    localparam int HALF = BD / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx [2];
    logic [7:0] dout [2];
    logic       dv [2], fe [2], pe [2], bz [2], dok [2];
    logic [3:0] dg [2];

    typedef struct {
        logic [7:0] data;
        bit         ferr;
        bit         perr;
        int         c0;
        int         lat;
    } item_t;

    item_t q0[$], q1[$];
    item_t mon_e;
    int    checks = 0, errors = 0, cyc = 0;
    bit    prev_dv [2];

    uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data_out(dout[0]), .data_valid(dv[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .busy(bz[0]), .digit(dg[0]), .digit_ok(dok[0]));

    uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data_out(dout[1]), .data_valid(dv[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .busy(bz[1]), .digit(dg[1]), .digit_ok(dok[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int exp_digit(input logic [7:0] d);
        return (d >= 8'h30 && d <= 8'h39) ? int'(d) - 48 : 15;
    endfunction

    // Monitor: every strobe must match the oldest outstanding frame of that instance.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dv[i]) begin
                chk($sformatf("strobe_width%0d", i), int'(prev_dv[i]), 0);
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe%0d: got strobe with data %0h, required none", i, dout[i]);
                end else begin
                    mon_e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("data%0d", i),     int'(dout[i]), int'(mon_e.data));
                    chk($sformatf("ferr%0d", i),     int'(fe[i]),   int'(mon_e.ferr));
                    chk($sformatf("perr%0d", i),     int'(pe[i]),   int'(mon_e.perr));
                    chk($sformatf("digit%0d", i),    int'(dg[i]),   exp_digit(mon_e.data));
                    chk($sformatf("digit_ok%0d", i), int'(dok[i]),  int'(exp_digit(mon_e.data) != 15));
                    chk($sformatf("latency%0d", i),  cyc - mon_e.c0 + 1, mon_e.lat);
                end
            end
            prev_dv[i] <= dv[i];
        end
    end

    task automatic drive(input int i, input bit b, input int n);
        rx[i] = b;
        repeat (n) @(negedge clk);
    endtask

    // pbit < 0 sends the correct even-parity bit; sbad bit s forces stop bit s low.
    task automatic send(input int i, input logic [7:0] d, input int pbit,
                        input logic [1:0] sbad, input int gap);
        int         nd = (i == 0) ? 8 : 7;
        int         sb = (i == 0) ? 1 : 2;
        int         p;
        logic [7:0] m;
        logic [1:0] smask;
        bit         bits[$];
        item_t      it;
        m     = d & 8'((1 << nd) - 1);
        smask = (sb == 1) ? 2'b01 : 2'b11;
        bits.push_back(1'b0);
        for (int k = 0; k < nd; k++) bits.push_back(m[k]);
        p = 0;
        if (i == 1) begin
            p = (pbit < 0) ? ($countones(m) % 2) : pbit;
            bits.push_back(p[0]);
        end
        for (int s = 0; s < sb; s++) bits.push_back(!sbad[s]);
        it.data = m;
        it.ferr = |(sbad & smask);
        it.perr = (i == 1) && ((($countones(m) + p) % 2) != 0);
        it.lat  = 3 + HALF + (bits.size() - 1) * BD;
        it.c0   = cyc + 1;
        if (i == 0) q0.push_back(it);
        else        q1.push_back(it);
        foreach (bits[k]) drive(i, bits[k], BD);
        drive(i, 1'b1, gap);
    endtask

    task automatic chk_reset(input int i);
        chk("rst_data", int'(dout[i]), 0);
        chk("rst_valid", int'(dv[i]), 0);
        chk("rst_ferr", int'(fe[i]), 0);
        chk("rst_perr", int'(pe[i]), 0);
        chk("rst_busy", int'(bz[i]), 0);
        chk("rst_digit", int'(dg[i]), 15);
        chk("rst_digit_ok", int'(dok[i]), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish, required finish within 5 ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] sb;
        int         pb;
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        send(0, 8'h35, -1, 2'b00, 5);
        send(0, 8'h41, -1, 2'b00, 0);
        send(0, 8'h39, -1, 2'b00, 5);
        send(0, 8'h41, -1, 2'b00, 5);

        // Glitch shorter than half a bit: busy briefly, then no frame.
        drive(0, 1'b0, 4);
        chk("glitch_busy_high", int'(bz[0]), 1);
        drive(0, 1'b1, 20);
        chk("glitch_busy_low", int'(bz[0]), 0);
        chk("glitch_data_kept", int'(dout[0]), 8'h41);

        send(0, 8'h55, -1, 2'b01, 5);
        send(0, 8'h37, -1, 2'b00, 5);

        send(1, 8'h33, 0, 2'b00, 5);
        send(1, 8'h33, 1, 2'b00, 5);
        send(1, 8'h33, -1, 2'b10, 5);
        send(1, 8'h34, -1, 2'b00, 5);

        for (int n = 0; n < 32; n++) begin
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            send(n % 2, d, pb, sb, (sb != 0) ? int'($urandom_range(2, 8)) : int'($urandom_range(0, 4)));
        end
        repeat (30) @(negedge clk);

        // Reset in the middle of data bit 4 (a low bit of 0xA5), released while rx is low.
        drive(0, 1'b0, BD);
        drive(0, 1'b1, BD);
        drive(0, 1'b0, BD);
        drive(0, 1'b1, BD);
        drive(0, 1'b0, BD);
        drive(0, 1'b0, HALF);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 20);
        chk("arm_busy_low", int'(bz[0]), 0);
        drive(0, 1'b1, 30);
        send(0, 8'h30, -1, 2'b00, 5);

        repeat (40) @(negedge clk);
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
